// File: rtl/id_exe_skid_buf.sv
// Two-entry decode-to-execute skid buffer; ds_allowin is driven from a flop only.
// Optional build macro ID_EXE_STALL_CNT_EN adds the stall_cnt backpressure counter port.
//
// state {main_v,skid_v} | meaning
// 00                    | empty, accept loads main
// 10                    | one op on es_*, accept goes to skid unless main is consumed
// 11                    | full, decode blocked until main is consumed
// 01                    | unreachable, recovers to empty

module id_exe_skid_buf #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 14,
   parameter int DEST_W = 5
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic              ds_valid,
   output logic              ds_allowin,
   input  logic [OP_W-1:0]   ds_alu_op,
   input  logic [DATA_W-1:0] ds_src1,
   input  logic [DATA_W-1:0] ds_src2,
   input  logic [DEST_W-1:0] ds_dest,
   input  logic [DATA_W-1:0] ds_pc,
   output logic              es_valid,
   input  logic              es_allowin,
   output logic [OP_W-1:0]   es_alu_op,
   output logic [DATA_W-1:0] es_alu_src1,
   output logic [DATA_W-1:0] es_alu_src2,
   output logic [DEST_W-1:0] es_dest,
   output logic [DATA_W-1:0] es_pc,
   output logic [1:0]        occupancy
`ifdef ID_EXE_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   logic main_v, skid_v;
   logic main_v_nxt, skid_v_nxt;
   logic ld_main_ds, ld_main_skid, ld_skid;
   logic accept, consume;

   logic [OP_W-1:0]   main_op,   skid_op;
   logic [DATA_W-1:0] main_src1, skid_src1;
   logic [DATA_W-1:0] main_src2, skid_src2;
   logic [DEST_W-1:0] main_dest, skid_dest;
   logic [DATA_W-1:0] main_pc,   skid_pc;

   assign accept  = ds_valid & ~skid_v;
   assign consume = main_v & es_allowin;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
      end else begin
         main_v <= main_v_nxt;
         skid_v <= skid_v_nxt;
      end
   end

   always_comb begin
      main_v_nxt   = main_v;
      skid_v_nxt   = skid_v;
      ld_main_ds   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      if (flush) begin
         main_v_nxt = 1'b0;
         skid_v_nxt = 1'b0;
      end else begin
         case ({main_v, skid_v})
            2'b00: begin
               if (accept) begin
                  main_v_nxt = 1'b1;
                  ld_main_ds = 1'b1;
               end
            end
            2'b10: begin
               if (accept && consume) begin
                  ld_main_ds = 1'b1;
               end else if (consume) begin
                  main_v_nxt = 1'b0;
               end else if (accept) begin
                  skid_v_nxt = 1'b1;
                  ld_skid    = 1'b1;
               end
            end
            2'b11: begin
               if (consume) begin
                  skid_v_nxt   = 1'b0;
                  ld_main_skid = 1'b1;
               end
            end
            default: begin
               main_v_nxt = 1'b0;
               skid_v_nxt = 1'b0;
            end
         endcase
      end
   end

   // Data only moves on a load strobe so ALU inputs stay put while stalled.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         main_op   <= '0;
         main_src1 <= '0;
         main_src2 <= '0;
         main_dest <= '0;
         main_pc   <= '0;
         skid_op   <= '0;
         skid_src1 <= '0;
         skid_src2 <= '0;
         skid_dest <= '0;
         skid_pc   <= '0;
      end else begin
         if (ld_main_ds) begin
            main_op   <= ds_alu_op;
            main_src1 <= ds_src1;
            main_src2 <= ds_src2;
            main_dest <= ds_dest;
            main_pc   <= ds_pc;
         end else if (ld_main_skid) begin
            main_op   <= skid_op;
            main_src1 <= skid_src1;
            main_src2 <= skid_src2;
            main_dest <= skid_dest;
            main_pc   <= skid_pc;
         end
         if (ld_skid) begin
            skid_op   <= ds_alu_op;
            skid_src1 <= ds_src1;
            skid_src2 <= ds_src2;
            skid_dest <= ds_dest;
            skid_pc   <= ds_pc;
         end
      end
   end

   always_comb begin
      ds_allowin  = ~skid_v;
      es_valid    = main_v;
      es_alu_op   = main_op & {OP_W{main_v}};
      es_alu_src1 = main_src1;
      es_alu_src2 = main_src2;
      es_dest     = main_dest;
      es_pc       = main_pc;
      occupancy   = {main_v & skid_v, main_v ^ skid_v};
   end

`ifdef ID_EXE_STALL_CNT_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stall_cnt <= '0;
      end else if (main_v && !es_allowin && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_exe_skid_buf.sv
// Directed self-checking bench for id_exe_skid_buf: reset, streaming, backpressure,
// simultaneous accept/consume, flush priority, mid-op reset and optional stall counter.

module tb_id_exe_skid_buf;

   localparam int DATA_W = 32;
   localparam int OP_W   = 14;
   localparam int DEST_W = 5;

   localparam logic [OP_W-1:0] OP_ADD = 14'h0001;
   localparam logic [OP_W-1:0] OP_SUB = 14'h0002;
   localparam logic [OP_W-1:0] OP_XOR = 14'h0080;

   logic              clk = 1'b0;
   logic              resetn;
   logic              flush;
   logic              ds_valid;
   logic              ds_allowin;
   logic [OP_W-1:0]   ds_alu_op;
   logic [DATA_W-1:0] ds_src1;
   logic [DATA_W-1:0] ds_src2;
   logic [DEST_W-1:0] ds_dest;
   logic [DATA_W-1:0] ds_pc;
   logic              es_valid;
   logic              es_allowin;
   logic [OP_W-1:0]   es_alu_op;
   logic [DATA_W-1:0] es_alu_src1;
   logic [DATA_W-1:0] es_alu_src2;
   logic [DEST_W-1:0] es_dest;
   logic [DATA_W-1:0] es_pc;
   logic [1:0]        occupancy;
`ifdef ID_EXE_STALL_CNT_EN
   logic [31:0]       stall_cnt;
`endif

   int n_chk = 0;
   int n_err = 0;

   id_exe_skid_buf #(.DATA_W(DATA_W), .OP_W(OP_W), .DEST_W(DEST_W)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .flush       (flush),
      .ds_valid    (ds_valid),
      .ds_allowin  (ds_allowin),
      .ds_alu_op   (ds_alu_op),
      .ds_src1     (ds_src1),
      .ds_src2     (ds_src2),
      .ds_dest     (ds_dest),
      .ds_pc       (ds_pc),
      .es_valid    (es_valid),
      .es_allowin  (es_allowin),
      .es_alu_op   (es_alu_op),
      .es_alu_src1 (es_alu_src1),
      .es_alu_src2 (es_alu_src2),
      .es_dest     (es_dest),
      .es_pc       (es_pc),
      .occupancy   (occupancy)
`ifdef ID_EXE_STALL_CNT_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [OP_W-1:0] op, input logic [DATA_W-1:0] s1,
                        input logic [DATA_W-1:0] s2, input logic [DEST_W-1:0] d,
                        input logic [DATA_W-1:0] pc);
      ds_valid  = v;
      ds_alu_op = op;
      ds_src1   = s1;
      ds_src2   = s2;
      ds_dest   = d;
      ds_pc     = pc;
   endtask

   task automatic chk_es(input string tag, input logic v, input logic [OP_W-1:0] op,
                         input logic [DATA_W-1:0] s1, input logic [DATA_W-1:0] s2,
                         input logic [1:0] occ, input logic alw);
      chk({tag, ".valid"}, 64'(es_valid), 64'(v));
      chk({tag, ".op"}, 64'(es_alu_op), 64'(op));
      chk({tag, ".src1"}, 64'(es_alu_src1), 64'(s1));
      chk({tag, ".src2"}, 64'(es_alu_src2), 64'(s2));
      chk({tag, ".occ"}, 64'(occupancy), 64'(occ));
      chk({tag, ".allowin"}, 64'(ds_allowin), 64'(alw));
   endtask

   initial begin
      resetn = 1'b0;
      flush = 1'b0;
      es_allowin = 1'b0;
      drive(1'b0, '0, '0, '0, '0, '0);
      #2;
      chk_es("reset", 1'b0, '0, '0, '0, 2'd0, 1'b1);
      #20;
      resetn = 1'b1;
      step();

      // streaming: op i appears one cycle after it is offered
      es_allowin = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         drive(1'b1, OP_ADD, DATA_W'(i), DATA_W'(2 * i), DEST_W'(i), DATA_W'(4 * i));
         step();
         chk_es($sformatf("stream%0d", i), 1'b1, OP_ADD, DATA_W'(i), DATA_W'(2 * i), 2'd1, 1'b1);
         chk($sformatf("stream%0d.dest", i), 64'(es_dest), 64'(i));
         chk($sformatf("stream%0d.pc", i), 64'(es_pc), 64'(4 * i));
      end
      drive(1'b0, '0, '0, '0, '0, '0);
      step();
      chk_es("drain", 1'b0, '0, 32'd6, 32'd12, 2'd0, 1'b1);

      // backpressure: A then B arrive while downstream stalls
      es_allowin = 1'b0;
      drive(1'b1, OP_ADD, 32'd5, 32'd7, 5'd1, 32'h100);
      step();
      chk_es("bp_a", 1'b1, OP_ADD, 32'd5, 32'd7, 2'd1, 1'b1);
      drive(1'b1, OP_SUB, 32'd9, 32'd4, 5'd2, 32'h104);
      step();
      chk_es("bp_b", 1'b1, OP_ADD, 32'd5, 32'd7, 2'd2, 1'b0);
      drive(1'b1, OP_XOR, 32'hDEAD, 32'hBEEF, 5'd3, 32'h108);
      step();
      chk_es("bp_hold", 1'b1, OP_ADD, 32'd5, 32'd7, 2'd2, 1'b0);
      chk("bp_hold.pc", 64'(es_pc), 64'h100);
      drive(1'b0, '0, '0, '0, '0, '0);
      es_allowin = 1'b1;
      step();
      chk_es("rel_a", 1'b1, OP_SUB, 32'd9, 32'd4, 2'd1, 1'b1);
      chk("rel_a.dest", 64'(es_dest), 64'd2);
      chk("rel_a.pc", 64'(es_pc), 64'h104);

      // accept C while B is consumed
      drive(1'b1, OP_XOR, 32'd3, 32'd6, 5'd7, 32'h200);
      step();
      chk_es("acc_cons", 1'b1, OP_XOR, 32'd3, 32'd6, 2'd1, 1'b1);
      drive(1'b0, '0, '0, '0, '0, '0);
      step();
      chk_es("acc_drain", 1'b0, '0, 32'd3, 32'd6, 2'd0, 1'b1);

      // flush wins over a simultaneous accept and consume
      es_allowin = 1'b0;
      drive(1'b1, OP_ADD, 32'd11, 32'd12, 5'd4, 32'h300);
      step();
      drive(1'b1, OP_SUB, 32'd13, 32'd14, 5'd5, 32'h304);
      step();
      chk("fl_pre.occ", 64'(occupancy), 64'd2);
      drive(1'b1, OP_XOR, 32'd15, 32'd16, 5'd6, 32'h308);
      es_allowin = 1'b1;
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fl.valid", 64'(es_valid), 64'd0);
      chk("fl.op", 64'(es_alu_op), 64'd0);
      chk("fl.occ", 64'(occupancy), 64'd0);
      chk("fl.allowin", 64'(ds_allowin), 64'd1);
      drive(1'b0, '0, '0, '0, '0, '0);
      step();
      chk("fl_post.valid", 64'(es_valid), 64'd0);
      chk("fl_post.occ", 64'(occupancy), 64'd0);

      // reset mid-operation loses buffered ops at once
      es_allowin = 1'b0;
      drive(1'b1, OP_ADD, 32'd21, 32'd22, 5'd8, 32'h400);
      step();
      chk("mr_pre.occ", 64'(occupancy), 64'd1);
      drive(1'b0, '0, '0, '0, '0, '0);
      #2;
      resetn = 1'b0;
      #1;
      chk_es("mid_reset", 1'b0, '0, '0, '0, 2'd0, 1'b1);
      resetn = 1'b1;
      step();
      chk("mr_post.occ", 64'(occupancy), 64'd0);

`ifdef ID_EXE_STALL_CNT_EN
      chk("sc_reset", 64'(stall_cnt), 64'd0);
      drive(1'b1, OP_ADD, 32'd1, 32'd2, 5'd1, 32'h500);
      step();
      drive(1'b0, '0, '0, '0, '0, '0);
      for (int i = 0; i < 10; i++) step();
      chk("sc_10", 64'(stall_cnt), 64'd10);
      es_allowin = 1'b1;
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      chk("sc_flush", 64'(stall_cnt), 64'd10);
      chk("sc_flush.occ", 64'(occupancy), 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/id_exe_skid_buf.md
Name: id_exe_skid_buf

Overview:
- Two-entry skid buffer between the decode stage and the execute-stage ALU.
- Registers the ALU control word, both operands, destination register and PC.
- Presents them to the ALU with a valid/allowin handshake.
- Downstream backpressure never reaches the decode stage combinationally; ds_allowin is a pure register output.
- Flush input discards in-flight ops on exception/branch redirect.

Parameters:
- DATA_W, 32, operand and PC width
- OP_W, 14, one-hot ALU control width (add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui, andn, orn)
- DEST_W, 5, destination register index width

Ports:
- clk  in  1  core clock
- resetn  in  1  reset, asynchronous assert, active-low
- flush  in  1  discard all buffered entries
- ds_valid  in  1  decode stage offers an op
- ds_allowin  out  1  buffer can accept an op this cycle
- ds_alu_op  in  OP_W  one-hot ALU control
- ds_src1  in  DATA_W  ALU operand 1 (rj)
- ds_src2  in  DATA_W  ALU operand 2 (rk or immediate)
- ds_dest  in  DEST_W  destination register
- ds_pc  in  DATA_W  instruction PC
- es_valid  out  1  op presented to ALU/downstream
- es_allowin  in  1  downstream consumes the op this cycle
- es_alu_op  out  OP_W  to ALU; forced to 0 when es_valid=0
- es_alu_src1  out  DATA_W  to ALU
- es_alu_src2  out  DATA_W  to ALU
- es_dest  out  DEST_W  destination register
- es_pc  out  DATA_W  PC
- occupancy  out  2  entries held, 0..2

Behaviour:
- Two entries: main (drives es_*) and skid. Valid bits are main_v and skid_v.
- Async reset (resetn=0): main_v=0, skid_v=0, all data registers 0. Outputs during reset: es_valid=0, es_alu_op=0, ds_allowin=1, occupancy=0.
- ds_allowin = ~skid_v, taken directly from a flop. No combinational path from es_allowin.
- Handshakes: accept = ds_valid & ds_allowin; consume = main_v & es_allowin.
- es_valid = main_v. es_* data comes from the main registers. es_alu_op is AND-gated with main_v, so the ALU sees an all-zero op (result 0) when idle.
- Per-edge transitions, no flush (state = main_v, skid_v):
  - 0,0: accept loads main.
  - 1,0: consume only empties main. Accept only loads skid. Accept and consume together reload main with the new op.
  - 1,1: ds_allowin=0. Consume moves skid to main and clears skid_v.
  - 1,1 without consume: hold everything.
- Order is strictly FIFO. The skid entry never overtakes main.
- An op is consumed at most once; a consume with main_v=0 is ignored.
- Latency: an op accepted in cycle N appears on es_* in cycle N+1 when the buffer was empty.
- flush=1 at an edge clears main_v and skid_v. Flush wins over a simultaneous accept and consume; the incoming op is dropped. Data registers may keep stale values. Next cycle: ds_allowin=1, es_valid=0.
- Reset mid-operation: buffered ops are lost, with no partial state.
- occupancy = main_v + skid_v, registered-equivalent, never 3.
- Data registers load only on accept or skid-to-main move, so they hold steady while stalled. This gives a stable ALU input under backpressure.

Optional Feature:
- Macro: ID_EXE_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt (32 bits).
  - Increments on every cycle with main_v & ~es_allowin.
  - Saturates at 0xFFFFFFFF.
  - Cleared by reset only, not by flush.
- Undefined: the counter and port are absent; all other behaviour is identical.

Test Plan:
- Reset then idle:
  - Drive resetn=0 mid-cycle → es_valid=0, es_alu_op=0, ds_allowin=1, occupancy=0 immediately.
- Streaming:
  - ds_valid=1 every cycle, es_allowin=1, ops with src1=i, src2=2i → es_* match op i one cycle later, one per cycle.
  - ds_allowin stays 1 throughout.
- Backpressure:
  - es_allowin=0 while ops A (add, 5, 7) and B (sub, 9, 4) arrive → occupancy=2 and ds_allowin=0 the cycle after B.
  - ALU inputs stay A.
  - Release es_allowin → A then B are consumed in order; ds_allowin=1 after A is consumed.
- Simultaneous accept and consume with one entry held:
  - New op C arrives while A is consumed → C in main next cycle, occupancy=1.
- Flush priority:
  - occupancy=2, assert flush together with ds_valid=1 and es_allowin=1 → next cycle es_valid=0, occupancy=0, incoming op dropped.
- ID_EXE_STALL_CNT_EN:
  - Hold es_allowin=0 for 10 cycles with main_v=1 → stall_cnt=10.
  - Apply flush → stall_cnt stays 10.
